// File: rtl/adder_bist_3_4bits.sv
// adder_bist_3_4bits: built-in self-test controller for a three-operand
// 4-bit adder with carry-in and two weight-16 carry-outs.
// It drives registered operand vectors, waits SETTLE_CYCLES, checks the
// returned sum against the golden total, and reports pass/err_count/fail_vec.
// Optional feature macro: ADDER_BIST_EXHAUSTIVE_EN replaces the 16-bit LFSR
// vector source with a 13-bit counter sweeping all 8192 vectors.
module adder_bist_3_4bits #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_vectors,
    output logic [3:0]  in1,
    output logic [3:0]  in2,
    output logic [3:0]  in3,
    output logic        cin,
    input  logic [3:0]  sum,
    input  logic        cout_1,
    input  logic        cout_2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [12:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 32'd1);

`ifdef ADDER_BIST_EXHAUSTIVE_EN
    localparam int SRC_W = 13;
    localparam logic [SRC_W-1:0] SRC_INIT = 13'd0;

    // Exhaustive sweep: the vector source is a plain up-counter.
    function automatic logic [SRC_W-1:0] src_step(input logic [SRC_W-1:0] s);
        return s + 13'd1;
    endfunction
`else
    localparam int SRC_W = 16;
    // A zero seed would lock the LFSR, so it falls back to the default seed.
    localparam logic [SRC_W-1:0] SRC_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    // Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifting towards bit 0.
    function automatic logic [SRC_W-1:0] src_step(input logic [SRC_W-1:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction
`endif

    // Golden total of the applied vector {cin,in3,in2,in1}, 7 bits wide.
    function automatic logic [6:0] golden_total(input logic [12:0] v);
        return {3'b000, v[3:0]} + {3'b000, v[7:4]} + {3'b000, v[11:8]} + {6'b000000, v[12]};
    endfunction

    // Total reported by the adder under test; each carry-out weighs 16.
    function automatic logic [6:0] observed_total(input logic [3:0] s,
                                                  input logic       c1,
                                                  input logic       c2);
        return {3'b000, s} + {2'b00, c1, 4'b0000} + {2'b00, c2, 4'b0000};
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [SRC_W-1:0]  src_r;
    logic [SRC_W-1:0]  src_s;
    logic [SRC_W-1:0]  src_adv_s;
    logic [13:0]       idx_r;
    logic [13:0]       idx_s;
    logic [13:0]       n_r;
    logic [13:0]       n_s;
    logic [13:0]       n_start_s;
    logic [3:0]        settle_cnt_r;
    logic [3:0]        settle_cnt_s;
    logic [12:0]       vec_r;
    logic [12:0]       vec_s;
    logic [12:0]       init_vec_s;
    logic [7:0]        err_r;
    logic [7:0]        err_s;
    logic [12:0]       fail_r;
    logic [12:0]       fail_s;
    logic              done_r;
    logic              done_s;
    logic              pass_r;
    logic              pass_s;
    logic              busy_r;
    logic              mismatch_s;
    logic              last_s;

`ifdef ADDER_BIST_EXHAUSTIVE_EN
    assign n_start_s = 14'd8192;
`else
    assign n_start_s = {6'd0, num_vectors};
`endif

    assign src_adv_s  = src_step(src_r);
    assign init_vec_s = SRC_INIT[12:0];
    assign mismatch_s = (observed_total(sum, cout_1, cout_2) != golden_total(vec_r));
    assign last_s     = ((idx_r + 14'd1) == n_r);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = (n_start_s == 14'd0) ? ST_DONE : ST_SETTLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values, chosen by the current state.
    always_comb begin
        src_s        = src_r;
        idx_s        = idx_r;
        n_s          = n_r;
        settle_cnt_s = settle_cnt_r;
        vec_s        = vec_r;
        err_s        = err_r;
        fail_s       = fail_r;
        done_s       = done_r;
        pass_s       = pass_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    src_s        = SRC_INIT;
                    idx_s        = 14'd0;
                    n_s          = n_start_s;
                    settle_cnt_s = 4'd0;
                    err_s        = 8'd0;
                    fail_s       = 13'd0;
                    if (n_start_s == 14'd0) begin
                        // Empty run: report a clean result straight away.
                        done_s = 1'b1;
                        pass_s = 1'b1;
                    end else begin
                        vec_s  = init_vec_s;
                        done_s = 1'b0;
                        pass_s = 1'b0;
                    end
                end else begin
                    done_s = done_r;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    settle_cnt_s = 4'd0;
                end else begin
                    settle_cnt_s = settle_cnt_r + 4'd1;
                end
            end
            ST_CHECK: begin
                src_s = src_adv_s;
                if (mismatch_s) begin
                    err_s = (err_r == 8'hFF) ? 8'hFF : (err_r + 8'd1);
                    if (err_r == 8'd0) begin
                        fail_s = vec_r;
                    end else begin
                        fail_s = fail_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if (last_s) begin
                    // Operands keep the last vector while in DONE.
                    done_s = 1'b1;
                    pass_s = (err_s == 8'd0);
                end else begin
                    vec_s = src_adv_s[12:0];
                    idx_s = idx_r + 14'd1;
                end
            end
            default: begin
                done_s = done_r;
            end
        endcase
    end

    // Datapath and output registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_r        <= '0;
            idx_r        <= 14'd0;
            n_r          <= 14'd0;
            settle_cnt_r <= 4'd0;
            vec_r        <= 13'd0;
            err_r        <= 8'd0;
            fail_r       <= 13'd0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            src_r        <= src_s;
            idx_r        <= idx_s;
            n_r          <= n_s;
            settle_cnt_r <= settle_cnt_s;
            vec_r        <= vec_s;
            err_r        <= err_s;
            fail_r       <= fail_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            busy_r       <= (state_s == ST_SETTLE) || (state_s == ST_CHECK);
        end
    end

    assign in1       = vec_r[3:0];
    assign in2       = vec_r[7:4];
    assign in3       = vec_r[11:8];
    assign cin       = vec_r[12];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_vec  = fail_r;

endmodule

// File: tb/tb_adder_bist_3_4bits.sv
// Self-checking bench for adder_bist_3_4bits. A behavioural adder with
// selectable faults sits on the DUT's adder-side ports; a reference model
// replays each run with plain arithmetic to predict the verdict.
module tb_adder_bist_3_4bits;

    localparam logic [15:0] SEED   = 16'h0301;
    localparam int          S      = 1;
    localparam int          BUDGET = 20000;
`ifdef ADDER_BIST_EXHAUSTIVE_EN
    localparam int          N_TBL  = 2;
`else
    localparam int          N_TBL  = 8;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_vectors = 8'd0;
    logic [3:0]  in1, in2, in3, sum;
    logic        cin, cout_1, cout_2, busy, done, pass;
    logic [7:0]  err_count;
    logic [12:0] fail_vec;

    int mode = 0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int nv;
        int md;
        int n;
        int e;
        int f;
        int l;
    } rec_t;

    rec_t tbl[N_TBL];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adder_bist_3_4bits #(.SEED(SEED), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .in1(in1), .in2(in2), .in3(in3), .cin(cin),
        .sum(sum), .cout_1(cout_1), .cout_2(cout_2),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    // Adder under test: 0 correct, 1 sum[0] stuck at 0, 2 constant sum=5, 3 cout_1 inverted.
    function automatic logic [5:0] model_adder(input int md, input logic [12:0] v);
        int t, sm, c1, c2;
        t  = int'(v[3:0]) + int'(v[7:4]) + int'(v[11:8]) + int'(v[12]);
        sm = t % 16;
        c1 = (t >= 16) ? 1 : 0;
        c2 = (t >= 32) ? 1 : 0;
        case (md)
            1: sm = sm & 14;
            2: begin sm = 5; c1 = 0; c2 = 0; end
            3: c1 = 1 - c1;
            default: ;
        endcase
        return {c2[0], c1[0], sm[3:0]};
    endfunction

    always_comb {cout_2, cout_1, sum} = model_adder(mode, {cin, in3, in2, in1});

    // Reference: list the vectors of a run and count what the adder gets wrong.
    task automatic ref_run(input int nv, input int md,
                           output int n, output int err, output int fv, output int last);
        int unsigned s;
        int v, golden, seen;
        logic [5:0] r;
        s = (SEED == 16'h0000) ? 32'hACE1 : 32'(SEED);
        n = nv;
`ifdef ADDER_BIST_EXHAUSTIVE_EN
        s = 0;
        n = 8192;
`endif
        err = 0; fv = 0; last = 0;
        for (int k = 0; k < n; k++) begin
            v = int'(s % 8192);
            golden = (v % 16) + ((v / 16) % 16) + ((v / 256) % 16) + ((v / 4096) % 2);
            r = model_adder(md, 13'(v));
            seen = int'(r[3:0]) + 16 * int'(r[4]) + 16 * int'(r[5]);
            if (seen != golden) begin
                if (err == 0) fv = v;
                if (err < 255) err = err + 1;
            end
            last = v;
`ifdef ADDER_BIST_EXHAUSTIVE_EN
            s = s + 1;
`else
            s = (s >> 1) | (((s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1) << 15);
`endif
        end
    endtask

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    // Pulse start for one cycle; t0 is the cycle count just after the sampling edge.
    task automatic start_run(input int nv, output int t0);
        @(negedge clk);
        start = 1'b1;
        num_vectors = 8'(nv);
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        while (done !== 1'b1 && (cyc - t0) < BUDGET) @(negedge clk);
        lat = (done === 1'b1) ? (cyc - t0) : -1;
    endtask

    task automatic apply_rec(input int id, input rec_t r, output int lat);
        int t0;
        mode = r.md;
        start_run(r.nv, t0);
        chk("busy_after_start", id, int'(busy), (r.n > 0) ? 1 : 0);
        wait_done(t0, lat);
        chk("latency", id, lat, r.n * (S + 1));
        chk("pass", id, int'(pass), (r.e == 0) ? 1 : 0);
        chk("err_count", id, int'(err_count), r.e);
        chk("fail_vec", id, int'(fail_vec), r.f);
        chk("busy_in_done", id, int'(busy), 0);
        if (r.n > 0) chk("last_vec", id, int'({cin, in3, in2, in1}), r.l);
    endtask

    initial begin
        int lat, t0;
        rec_t rr;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, int'(busy), 0);
        chk("rst_done", 0, int'(done), 0);
        chk("rst_pass", 0, int'(pass), 0);
        chk("rst_err", 0, int'(err_count), 0);
        chk("rst_fail_vec", 0, int'(fail_vec), 0);
        chk("rst_vec", 0, int'({cin, in3, in2, in1}), 0);
        reset = 1'b0;

        // Run table: {num_vectors, adder mode}; expectations from the reference.
        tbl[0].nv = 16;  tbl[0].md = 0;
        tbl[1].nv = 1;   tbl[1].md = 2;
        tbl[N_TBL-1].nv = 0; tbl[N_TBL-1].md = 0;
`ifndef ADDER_BIST_EXHAUSTIVE_EN
        tbl[1].nv = 64;  tbl[1].md = 1;
        tbl[2].nv = 1;   tbl[2].md = 0;
        tbl[3].nv = 1;   tbl[3].md = 2;
        tbl[4].nv = 255; tbl[4].md = 3;
        tbl[5].nv = 2;   tbl[5].md = 2;
        tbl[6].nv = 5;   tbl[6].md = 3;
`endif
        for (int i = 0; i < N_TBL; i++) begin
            ref_run(tbl[i].nv, tbl[i].md, tbl[i].n, tbl[i].e, tbl[i].f, tbl[i].l);
        end
        for (int i = 0; i < N_TBL; i++) begin
            apply_rec(i, tbl[i], lat);
        end

`ifndef ADDER_BIST_EXHAUSTIVE_EN
        // Hand-derived anchors: 16 vectors at one settle cycle end after edge 32.
        apply_rec(100, tbl[0], lat);
        chk("lat_16_vectors", 100, lat, 32);
        chk("pass_16_vectors", 100, int'(pass), 1);
        // Vector {cin=0,in3=3,in2=0,in1=1}: correct adder clean, sum=5 gives one error.
        apply_rec(101, tbl[2], lat);
        chk("vec0301_ok_err", 101, int'(err_count), 0);
        chk("vec0301_ok_in", 101, int'({cin, in3, in2, in1}), 13'h0301);
        apply_rec(102, tbl[3], lat);
        chk("vec0301_bad_err", 102, int'(err_count), 1);
        chk("vec0301_bad_fail_vec", 102, int'(fail_vec), 13'h0301);
        // Empty run is done one cycle after start.
        apply_rec(103, tbl[7], lat);
        chk("empty_lat", 103, lat, 0);
        chk("empty_pass", 103, int'(pass), 1);
`endif

        // start pulses while busy must not restart the run.
        rr.nv = 4; rr.md = 2;
        ref_run(rr.nv, rr.md, rr.n, rr.e, rr.f, rr.l);
        mode = rr.md;
        start_run(rr.nv, t0);
        @(negedge clk);
        start = 1'b1;
        num_vectors = 8'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, lat);
        chk("busy_start_lat", 200, lat, rr.n * (S + 1));
        chk("busy_start_err", 200, int'(err_count), rr.e);
        chk("busy_start_fail_vec", 200, int'(fail_vec), rr.f);

        // Reset in the middle of a 16-vector run, with start held high.
        mode = 0;
        start_run(16, t0);
        repeat (3) @(negedge clk);
        chk("midrun_busy", 300, int'(busy), 1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_busy", 300, int'(busy), 0);
        chk("abort_done", 300, int'(done), 0);
        chk("abort_pass", 300, int'(pass), 0);
        chk("abort_err", 300, int'(err_count), 0);
        chk("abort_fail_vec", 300, int'(fail_vec), 0);
        chk("abort_vec", 300, int'({cin, in3, in2, in1}), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("after_abort_busy", 301, int'(busy), 0);
        chk("after_abort_done", 301, int'(done), 0);

`ifndef ADDER_BIST_EXHAUSTIVE_EN
        // Randomised runs.
        for (int i = 0; i < 8; i++) begin
            rr.nv = int'($urandom_range(0, 40));
            rr.md = int'($urandom_range(0, 3));
            ref_run(rr.nv, rr.md, rr.n, rr.e, rr.f, rr.l);
            apply_rec(400 + i, rr, lat);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
